// File: rtl/rf_wport_arbiter.sv
// Shares the regfile/HI-LO write port between WB (always wins) and a buffered secondary result source.
// Optional macro RF_WPORT_HILO_EN: buffer and arbitrate the secondary HI/LO fields as well.
module rf_wport_arbiter #(
  parameter  int unsigned STARVE_LIMIT = 8,
  localparam int unsigned AW = 5,
  localparam int unsigned DW = 32,
  localparam int unsigned HW = 66
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pri_we,
  input  logic [AW-1:0] pri_waddr,
  input  logic [DW-1:0] pri_wdata,
  input  logic [HW-1:0] pri_hilo,
  input  logic          sec_valid,
  output logic          sec_ready,
  input  logic          sec_we,
  input  logic [AW-1:0] sec_waddr,
  input  logic [DW-1:0] sec_wdata,
  input  logic [HW-1:0] sec_hilo,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [HW-1:0] hilo_bus,
  output logic          stallreq,
  output logic          sec_pending
);

  localparam int unsigned CW = 4;

  typedef struct packed {
`ifdef RF_WPORT_HILO_EN
    logic [HW-1:0] hilo;
`endif
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } entry_t;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t        state, state_next;
  entry_t        mem [2];
  entry_t        sec_entry;
  entry_t        head;
  logic [1:0]    count;
  logic          wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          pri_act, sec_hilo_act, sec_noop;
  logic          empty, full, push, pop;

`ifdef RF_WPORT_HILO_EN
  assign pri_act      = pri_we | pri_hilo[HW-1] | pri_hilo[HW-2];
  assign sec_hilo_act = sec_hilo[HW-1] | sec_hilo[HW-2];
`else
  logic unused_sec_hilo;
  assign pri_act         = pri_we;
  assign sec_hilo_act    = 1'b0;
  assign unused_sec_hilo = ^sec_hilo;
`endif

  assign empty       = (count == 2'd0);
  assign full        = (count == 2'd2);
  assign sec_ready   = !full && !rst;
  // Entries that would write nothing are accepted but never occupy the FIFO.
  assign sec_noop    = (!sec_we || (sec_waddr == '0)) && !sec_hilo_act;
  assign push        = sec_valid && sec_ready && !sec_noop;
  assign pop         = !pri_act && !empty;
  assign head        = mem[rd_ptr];
  assign sec_pending = !empty;
  assign stallreq    = (state == HOLD);

  always_comb begin
    sec_entry       = '0;
    sec_entry.we    = sec_we;
    sec_entry.waddr = sec_waddr;
    sec_entry.wdata = sec_wdata;
`ifdef RF_WPORT_HILO_EN
    sec_entry.hilo  = sec_hilo;
`endif
  end

  // Write-port mux: WB first, then FIFO head, otherwise quiet.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    hilo_bus = '0;
    if (pri_act) begin
      rf_we    = pri_we;
      rf_waddr = pri_waddr;
      rf_wdata = pri_wdata;
      hilo_bus = pri_hilo;
    end else if (!empty) begin
      rf_we    = head.we && (head.waddr != '0);
      rf_waddr = head.waddr;
      rf_wdata = head.wdata;
`ifdef RF_WPORT_HILO_EN
      hilo_bus = head.hilo;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sec_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
      if (empty || pop) begin
        cnt <= '0;
      end else if (cnt != CW'(STARVE_LIMIT)) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stall request holds until the FIFO has been seen empty.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cnt == CW'(STARVE_LIMIT)) state_next = HOLD;
      HOLD:    if (empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Testbench for rf_wport_arbiter: directed vector table, corner-case sequences and
// randomized traffic against a queue-based reference model.
module tb_rf_wport_arbiter;

  localparam int unsigned LIMIT = 8;
`ifdef RF_WPORT_HILO_EN
  localparam bit HILO = 1'b1;
`else
  localparam bit HILO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pri_we;
  logic [4:0]  pri_waddr;
  logic [31:0] pri_wdata;
  logic [65:0] pri_hilo;
  logic        sec_valid;
  logic        sec_ready;
  logic        sec_we;
  logic [4:0]  sec_waddr;
  logic [31:0] sec_wdata;
  logic [65:0] sec_hilo;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [65:0] hilo_bus;
  logic        stallreq;
  logic        sec_pending;

  rf_wport_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pri_we(pri_we), .pri_waddr(pri_waddr), .pri_wdata(pri_wdata), .pri_hilo(pri_hilo),
    .sec_valid(sec_valid), .sec_ready(sec_ready),
    .sec_we(sec_we), .sec_waddr(sec_waddr), .sec_wdata(sec_wdata), .sec_hilo(sec_hilo),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .hilo_bus(hilo_bus),
    .stallreq(stallreq), .sec_pending(sec_pending)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: buffered results in arrival order plus starvation bookkeeping.
  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [65:0] hilo;
  } ment_t;

  ment_t       q[$];
  int unsigned starve = 0;
  bit          m_stall = 1'b0;

  typedef struct {
    logic        pri_we;
    logic [4:0]  pri_waddr;
    logic [31:0] pri_wdata;
    logic        sec_valid;
    logic        sec_we;
    logic [4:0]  sec_waddr;
    logic [31:0] sec_wdata;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_ready;
    logic        e_pending;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(int pw, int pa, int pd, int sv, int sw, int sa, int sd,
                              int ew, int ea, int ed, int er, int ep);
    vec_t v;
    v.pri_we    = (pw != 0);
    v.pri_waddr = 5'(pa);
    v.pri_wdata = 32'(pd);
    v.sec_valid = (sv != 0);
    v.sec_we    = (sw != 0);
    v.sec_waddr = 5'(sa);
    v.sec_wdata = 32'(sd);
    v.e_we      = (ew != 0);
    v.e_waddr   = 5'(ea);
    v.e_wdata   = 32'(ed);
    v.e_ready   = (er != 0);
    v.e_pending = (ep != 0);
    return v;
  endfunction

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic idle_inputs();
    pri_we = 1'b0; pri_waddr = '0; pri_wdata = '0; pri_hilo = '0;
    sec_valid = 1'b0; sec_we = 1'b0; sec_waddr = '0; sec_wdata = '0; sec_hilo = '0;
  endtask

  function automatic bit model_pri_act();
    return pri_we || (HILO && (pri_hilo[65] || pri_hilo[64]));
  endfunction

  // Compare every DUT output with the model, mid-cycle.
  task automatic sample();
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [65:0] e_hl;
    @(negedge clk);
    e_we = 1'b0; e_wa = '0; e_wd = '0; e_hl = '0;
    if (model_pri_act()) begin
      e_we = pri_we; e_wa = pri_waddr; e_wd = pri_wdata; e_hl = pri_hilo;
    end else if (q.size() > 0) begin
      e_we = q[0].we && (q[0].waddr != 5'd0);
      e_wa = q[0].waddr;
      e_wd = q[0].wdata;
      e_hl = HILO ? q[0].hilo : 66'd0;
    end
    chk("model rf_we",       66'(rf_we),       66'(e_we));
    chk("model rf_waddr",    66'(rf_waddr),    66'(e_wa));
    chk("model rf_wdata",    66'(rf_wdata),    66'(e_wd));
    chk("model hilo_bus",    hilo_bus,         e_hl);
    chk("model sec_ready",   66'(sec_ready),   66'(!rst && (q.size() < 2)));
    chk("model sec_pending", 66'(sec_pending), 66'(q.size() > 0));
    chk("model stallreq",    66'(stallreq),    66'(m_stall));
  endtask

  // Advance the model by one clock with the current inputs, then clock the DUT.
  task automatic advance();
    bit    pa, popped, noop, rdy, nxt_stall;
    ment_t e;
    pa = model_pri_act();
    if (rst) begin
      q.delete();
      starve  = 0;
      m_stall = 1'b0;
    end else begin
      rdy       = (q.size() < 2);
      popped    = !pa && (q.size() > 0);
      nxt_stall = m_stall ? (q.size() != 0) : (starve == LIMIT);
      if (q.size() == 0 || popped) starve = 0;
      else if (starve < LIMIT) starve++;
      if (popped) void'(q.pop_front());
      noop = (!sec_we || sec_waddr == 5'd0) && !(HILO && (sec_hilo[65] || sec_hilo[64]));
      if (sec_valid && rdy && !noop) begin
        e.we = sec_we; e.waddr = sec_waddr; e.wdata = sec_wdata;
        e.hilo = HILO ? sec_hilo : 66'd0;
        q.push_back(e);
      end
      m_stall = nxt_stall;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [65:0] hl;
    int unsigned p;

    tbl[0]  = mk(0, 0, 0,       0, 0, 0,  0,       0, 0,  0,       1, 0);
    tbl[1]  = mk(1, 5, 'h1234,  0, 0, 0,  0,       1, 5,  'h1234,  1, 0);
    tbl[2]  = mk(1, 3, 'h11,    1, 1, 7,  'hCAFE,  1, 3,  'h11,    1, 0);
    tbl[3]  = mk(1, 3, 'h22,    0, 0, 0,  0,       1, 3,  'h22,    1, 1);
    tbl[4]  = mk(1, 3, 'h33,    0, 0, 0,  0,       1, 3,  'h33,    1, 1);
    tbl[5]  = mk(0, 0, 0,       0, 0, 0,  0,       1, 7,  'hCAFE,  1, 1);
    tbl[6]  = mk(0, 0, 0,       0, 0, 0,  0,       0, 0,  0,       1, 0);
    tbl[7]  = mk(0, 0, 0,       1, 0, 9,  'h99,    0, 0,  0,       1, 0);
    tbl[8]  = mk(0, 0, 0,       0, 0, 0,  0,       0, 0,  0,       1, 0);
    tbl[9]  = mk(1, 1, 1,       1, 1, 10, 'hA,     1, 1,  1,       1, 0);
    tbl[10] = mk(0, 0, 0,       1, 1, 11, 'hB,     1, 10, 'hA,     1, 1);
    tbl[11] = mk(0, 0, 0,       0, 0, 0,  0,       1, 11, 'hB,     1, 1);
    tbl[12] = mk(0, 0, 0,       0, 0, 0,  0,       0, 0,  0,       1, 0);
    tbl[13] = mk(0, 0, 0,       1, 1, 12, 'hC,     0, 0,  0,       1, 0);
    tbl[14] = mk(0, 0, 0,       0, 0, 0,  0,       1, 12, 'hC,     1, 1);
    tbl[15] = mk(0, 0, 0,       0, 0, 0,  0,       0, 0,  0,       1, 0);

    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    sample();
    chk("reset sec_ready", 66'(sec_ready), 66'd0);
    chk("reset stallreq",  66'(stallreq),  66'd0);
    advance();
    rst = 1'b0;

    // Directed vectors from an idle, freshly reset block.
    for (int i = 0; i < 16; i++) begin
      idle_inputs();
      pri_we = tbl[i].pri_we; pri_waddr = tbl[i].pri_waddr; pri_wdata = tbl[i].pri_wdata;
      sec_valid = tbl[i].sec_valid; sec_we = tbl[i].sec_we;
      sec_waddr = tbl[i].sec_waddr; sec_wdata = tbl[i].sec_wdata;
      sample();
      chk($sformatf("vec%0d rf_we", i),       66'(rf_we),       66'(tbl[i].e_we));
      chk($sformatf("vec%0d rf_waddr", i),    66'(rf_waddr),    66'(tbl[i].e_waddr));
      chk($sformatf("vec%0d rf_wdata", i),    66'(rf_wdata),    66'(tbl[i].e_wdata));
      chk($sformatf("vec%0d hilo_bus", i),    hilo_bus,         66'd0);
      chk($sformatf("vec%0d sec_ready", i),   66'(sec_ready),   66'(tbl[i].e_ready));
      chk($sformatf("vec%0d sec_pending", i), 66'(sec_pending), 66'(tbl[i].e_pending));
      chk($sformatf("vec%0d stallreq", i),    66'(stallreq),    66'd0);
      advance();
    end

    // Starvation: WB busy every cycle, two entries buffered, a third held off.
    for (int c = 0; c < int'(LIMIT) + 3; c++) begin
      idle_inputs();
      pri_we = 1'b1; pri_waddr = 5'(c + 1); pri_wdata = 32'(c);
      sec_valid = 1'b1; sec_we = 1'b1;
      sec_waddr = 5'(20 + ((c > 1) ? 2 : c));
      sec_wdata = 32'(256 + ((c > 1) ? 2 : c));
      sample();
      chk($sformatf("starve%0d sec_ready", c),   66'(sec_ready),   66'(c < 2));
      chk($sformatf("starve%0d sec_pending", c), 66'(sec_pending), 66'(c >= 1));
      chk($sformatf("starve%0d stallreq", c),    66'(stallreq),    66'(c >= int'(LIMIT) + 2));
      advance();
    end
    idle_inputs();
    sample();
    chk("bubble0 rf_we",    66'(rf_we),    66'd1);
    chk("bubble0 rf_waddr", 66'(rf_waddr), 66'd20);
    chk("bubble0 rf_wdata", 66'(rf_wdata), 66'h100);
    chk("bubble0 stallreq", 66'(stallreq), 66'd1);
    advance();
    sample();
    chk("bubble1 rf_waddr", 66'(rf_waddr), 66'd21);
    chk("bubble1 rf_wdata", 66'(rf_wdata), 66'h101);
    chk("bubble1 stallreq", 66'(stallreq), 66'd1);
    advance();
    sample();
    chk("bubble2 sec_pending", 66'(sec_pending), 66'd0);
    chk("bubble2 rf_we",       66'(rf_we),       66'd0);
    chk("bubble2 stallreq",    66'(stallreq),    66'd1);
    advance();
    sample();
    chk("bubble3 stallreq", 66'(stallreq), 66'd0);
    advance();

    // r0 target carrying a HI/LO write.
    hl = {2'b11, 32'h1, 32'h2};
    idle_inputs();
    sec_valid = 1'b1; sec_we = 1'b1; sec_waddr = 5'd0; sec_wdata = 32'h55; sec_hilo = hl;
    sample();
    chk("r0 push no bypass", hilo_bus, 66'd0);
    advance();
    idle_inputs();
    sample();
    chk("r0 drain rf_we",    66'(rf_we),       66'd0);
    chk("r0 drain hilo_bus", hilo_bus,         HILO ? hl : 66'd0);
    chk("r0 drain pending",  66'(sec_pending), 66'(HILO));
    chk("r0 drain wdata",    66'(rf_wdata),    HILO ? 66'h55 : 66'd0);
    advance();
    sample();
    chk("r0 after pending",  66'(sec_pending), 66'd0);
    advance();

    // Reset in the middle of a stall: buffer lost, stallreq drops.
    for (int c = 0; c < int'(LIMIT) + 2; c++) begin
      idle_inputs();
      pri_we = 1'b1; pri_waddr = 5'd2; pri_wdata = 32'(c);
      sec_valid = (c == 0); sec_we = 1'b1; sec_waddr = 5'd9; sec_wdata = 32'h9;
      sample();
      advance();
    end
    idle_inputs();
    pri_we = 1'b1; pri_waddr = 5'd2; pri_wdata = 32'h77;
    rst = 1'b1;
    sample();
    chk("midrst stallreq before", 66'(stallreq),    66'd1);
    chk("midrst sec_ready",       66'(sec_ready),   66'd0);
    chk("midrst pending before",  66'(sec_pending), 66'd1);
    advance();
    rst = 1'b0;
    sample();
    chk("midrst stallreq after", 66'(stallreq),    66'd0);
    chk("midrst pending after",  66'(sec_pending), 66'd0);
    chk("midrst ready after",    66'(sec_ready),   66'd1);
    advance();

    // Randomized traffic with alternating busy/quiet WB windows.
    for (int i = 0; i < 3000; i++) begin
      p = ((i / 64) % 2 == 1) ? 95 : 40;
      rst       = ($urandom_range(0, 199) == 0);
      pri_we    = ($urandom_range(0, 99) < p);
      pri_waddr = 5'($urandom);
      pri_wdata = $urandom;
      pri_hilo  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), $urandom, $urandom};
      if (!HILO && !pri_we) pri_hilo = '0;
      sec_valid = ($urandom_range(0, 99) < 40);
      sec_we    = ($urandom_range(0, 3) != 0);
      sec_waddr = 5'($urandom_range(0, 3));
      sec_wdata = $urandom;
      sec_hilo  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom, $urandom};
      sample();
      advance();
    end

    rst = 1'b0;
    idle_inputs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
